ram: RTL and testbench
======================

# ram

Small single-port synchronous-write, asynchronous-read random-access memory, 16 words × 8 bits by default. It serves as the data memory of the team's simple 8-bit processor datapath. The control unit drives it with separate `MemWrite` and `MemRead` strobes. Writes commit on the clock edge. Reads are combinational and gated by `MemRead`.

## Interface
Clocking is fixed: one clock, `clk`. Reset is `reset`, synchronous and active-high.

Parameters:
- `ADDR_WIDTH`, default 4: address width; depth is 2^ADDR_WIDTH words.
- `DATA_WIDTH`, default 8: word width.

Ports:
- `clk`  input  1  single clock; all state updates occur on its rising edge.
- `reset`  input  1  synchronous, active-high; clears every word to zero.
- `MemWrite`  input  1  write strobe, sampled on the rising edge.
- `MemRead`  input  1  read enable; gates `MemData_out`.
- `Address`  input  ADDR_WIDTH  word address, shared by read and write.
- `WriteData`  input  DATA_WIDTH  data written when `MemWrite` = 1.
- `MemData_out`  output  DATA_WIDTH  read data.

## Operation
- Storage is an array of 2^ADDR_WIDTH words, each DATA_WIDTH bits wide.
- Reset: on a rising edge with `reset` = 1, all words become 0.
  - Reset has priority over `MemWrite`; a write presented in the same cycle is discarded.
- Write: on a rising edge with `reset` = 0 and `MemWrite` = 1, `mem[Address]` ← `WriteData`. No other word changes.
- Read, combinational:
  - `MemData_out` = `mem[Address]` when `MemRead` = 1.
  - `MemData_out` = 0 when `MemRead` = 0.
- `MemRead` and `MemWrite` may both be 1 at once. This is legal; the write still occurs.
- Every address value is valid. There is no out-of-range condition and no address wrap handling is needed.
- X/Z on `Address` while `MemRead` = 1 gives undefined output. The bench must not rely on it.
- Power-up contents before the first reset are undefined. Simulation models may initialise the array to 0.

## Timing
- Write latency: data is visible on the read path immediately after the rising edge that performs the write.
- Read latency: zero cycles. `MemData_out` follows `Address`/`MemRead` combinationally, with no registered stage.
- Read-during-write to the same address:
  - before the edge, `MemData_out` shows the old word;
  - after the edge, it shows the new word.
- Reset output values:
  - After the reset edge, every word reads 0.
  - `MemData_out` = 0 after the reset edge regardless of `MemRead`, since all words are 0.
- Reset mid-operation: a reset edge wipes all previously written data. The next write after reset deasserts behaves normally.
- No handshake or stall is required. One write per cycle is allowed, with unlimited back-to-back writes.

## Structure
- Shared package `ram_pkg`:
  - `RAM_ADDR_WIDTH` = 4;
  - `RAM_DATA_WIDTH` = 8;
  - typedefs `ram_addr_t` and `ram_word_t`.
- Single module `ram` with no sub-modules: one clocked process for reset/write, one combinational read assignment.
- Implementation must include parameter sanity checks (ADDR_WIDTH ≥ 1, DATA_WIDTH ≥ 1).
- Implementation must include simulation-only assertions:
  - no X on `MemWrite`/`MemRead` outside reset;
  - no X on `Address` when a strobe is high.

## Test plan
- Reset for 1 cycle, then `MemRead` = 1 and sweep all addresses 0–15 → every read returns 0x00.
- Write 0xAA to addr 1, then 0xF0 to addr 2 (single-cycle `MemWrite` pulses); set `MemRead` = 1 → addr 1 reads 0xAA, addr 2 reads 0xF0, addr 0 reads 0x00.
- `MemRead` = 0 with addr 1 holding 0xAA → `MemData_out` = 0x00; raise `MemRead` → 0xAA within the same cycle, with no clock edge needed.
- Same-address read-during-write: addr 3 holds 0x11; drive `MemWrite` = 1, `WriteData` = 0x22, `MemRead` = 1 → output 0x11 before the edge, 0x22 after.
- Assert `reset` and `MemWrite` (0x55 to addr 4) in the same cycle → addr 4 reads 0x00, and earlier writes are also cleared.
- Back-to-back writes to addresses 0–15 with data = addr × 0x11 → readback matches for every address; no aliasing.

Source files
------------

// File: rtl/ram_pkg.sv
// Shared widths and word/address types for the processor data memory.
package ram_pkg;

    localparam int RAM_ADDR_WIDTH = 4;
    localparam int RAM_DATA_WIDTH = 8;

    typedef logic [RAM_ADDR_WIDTH-1:0] ram_addr_t;
    typedef logic [RAM_DATA_WIDTH-1:0] ram_word_t;

endpackage : ram_pkg

// File: rtl/ram.sv
// Data memory for the 8-bit datapath: synchronous write, combinational read
// gated by MemRead, synchronous active-high clear of every word.
module ram
    import ram_pkg::*;
#(
    parameter int ADDR_WIDTH = RAM_ADDR_WIDTH,
    parameter int DATA_WIDTH = RAM_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  MemWrite,
    input  logic                  MemRead,
    input  logic [ADDR_WIDTH-1:0] Address,
    input  logic [DATA_WIDTH-1:0] WriteData,
    output logic [DATA_WIDTH-1:0] MemData_out
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    // Reject degenerate configurations at elaboration time.
    if (ADDR_WIDTH < 1) begin : g_bad_addr_width
        $error("ram: ADDR_WIDTH must be >= 1");
    end
    if (DATA_WIDTH < 1) begin : g_bad_data_width
        $error("ram: DATA_WIDTH must be >= 1");
    end

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    // Clear all words on reset, otherwise commit the addressed write.
    // NOTE: the clear-all reset forces this array into flops; a vendor block
    // RAM cannot be zeroed in one cycle, so keep the depth small.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                // NOTE: non-blocking so every word updates from the same
                // pre-edge state, as real flops do.
                mem_q[i] <= '0;
            end
        end else if (MemWrite) begin
            mem_q[Address] <= WriteData;
        end
    end

    // Combinational read; forced to zero when the read strobe is low.
    assign MemData_out = MemRead ? mem_q[Address] : '0;

    // Control strobes must be known whenever the memory is not being reset.
    a_strobes_known : assert property (
        @(posedge clk) disable iff (reset)
        !$isunknown({MemWrite, MemRead})
    ) else $error("ram: X/Z on MemWrite/MemRead");

    // The address must be known whenever either strobe uses it.
    a_addr_known : assert property (
        @(posedge clk) disable iff (reset)
        (MemWrite || MemRead) |-> !$isunknown(Address)
    ) else $error("ram: X/Z on Address while a strobe is high");

endmodule : ram

// File: tb/tb_ram.sv
// Directed self-checking bench for the ram data memory.
module tb_ram;
    import ram_pkg::*;

    logic      clk = 1'b0;
    logic      reset = 1'b1;
    logic      MemWrite = 1'b0;
    logic      MemRead = 1'b0;
    ram_addr_t Address = '0;
    ram_word_t WriteData = '0;
    ram_word_t MemData_out;

    int checks = 0;
    int errors = 0;

    ram #(
        .ADDR_WIDTH(RAM_ADDR_WIDTH),
        .DATA_WIDTH(RAM_DATA_WIDTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .MemWrite   (MemWrite),
        .MemRead    (MemRead),
        .Address    (Address),
        .WriteData  (WriteData),
        .MemData_out(MemData_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input ram_word_t expected);
        checks++;
        assert (MemData_out === expected) else begin
            errors++;
            $error("FAIL %s: observed 0x%02h expected 0x%02h", tag, MemData_out, expected);
        end
    endtask

    // Advance past the next rising edge and settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Single-cycle write pulse.
    task automatic write_word(input ram_addr_t a, input ram_word_t d);
        Address   = a;
        WriteData = d;
        MemWrite  = 1'b1;
        tick();
        MemWrite  = 1'b0;
    endtask

    // Read an address combinationally and compare.
    task automatic read_check(input string tag, input ram_addr_t a, input ram_word_t expected);
        MemRead = 1'b1;
        Address = a;
        #1;
        check(tag, expected);
    endtask

    initial begin
        // Reset for one cycle.
        tick();
        reset = 1'b0;
        #1;
        check("reset_read_low", 8'h00);

        // Post-reset sweep: every word reads zero.
        for (int a = 0; a < 16; a++) begin
            read_check($sformatf("reset_sweep_%0d", a), ram_addr_t'(a), 8'h00);
        end

        // Two single-cycle writes, then readback.
        MemRead = 1'b0;
        write_word(4'd1, 8'hAA);
        write_word(4'd2, 8'hF0);
        read_check("wr_addr1", 4'd1, 8'hAA);
        read_check("wr_addr2", 4'd2, 8'hF0);
        read_check("wr_addr0_untouched", 4'd0, 8'h00);

        // Read gating: low strobe forces zero, raising it shows data with no edge.
        Address = 4'd1;
        MemRead = 1'b0;
        #1;
        check("gate_low", 8'h00);
        MemRead = 1'b1;
        #1;
        check("gate_high_same_cycle", 8'hAA);

        // Read-during-write on the same address.
        write_word(4'd3, 8'h11);
        Address   = 4'd3;
        WriteData = 8'h22;
        MemWrite  = 1'b1;
        MemRead   = 1'b1;
        #1;
        check("rdw_before_edge", 8'h11);
        tick();
        MemWrite  = 1'b0;
        check("rdw_after_edge", 8'h22);

        // Reset wins over a simultaneous write and clears earlier data.
        reset     = 1'b1;
        MemWrite  = 1'b1;
        Address   = 4'd4;
        WriteData = 8'h55;
        tick();
        reset    = 1'b0;
        MemWrite = 1'b0;
        read_check("rst_beats_write_addr4", 4'd4, 8'h00);
        read_check("rst_clears_addr1", 4'd1, 8'h00);
        read_check("rst_clears_addr2", 4'd2, 8'h00);
        read_check("rst_clears_addr3", 4'd3, 8'h00);

        // First write after reset behaves normally.
        write_word(4'd4, 8'h5A);
        read_check("post_rst_write", 4'd4, 8'h5A);

        // Back-to-back writes across every address, then full readback.
        MemRead  = 1'b0;
        MemWrite = 1'b1;
        for (int a = 0; a < 16; a++) begin
            Address   = ram_addr_t'(a);
            WriteData = ram_word_t'(a * 17);
            tick();
        end
        MemWrite = 1'b0;
        for (int a = 0; a < 16; a++) begin
            read_check($sformatf("b2b_addr%0d", a), ram_addr_t'(a), ram_word_t'(a * 17));
        end

        // Gating still zeroes a non-zero word.
        Address = 4'd15;
        MemRead = 1'b0;
        #1;
        check("gate_low_addr15", 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_ram
